// File: rtl/cpu_pkg.sv
// Shared CPU constants: 5-bit ALU mode encodings ({opcode[7:5], opcode[1:0]}),
// addressing-mode encodings, the flag bundle type and a signed-overflow helper.
package cpu_pkg;

  // ALU operation select values
  localparam logic [4:0] MODE_ORA = 5'b00001;
  localparam logic [4:0] MODE_AND = 5'b00101;
  localparam logic [4:0] MODE_EOR = 5'b01001;
  localparam logic [4:0] MODE_ADC = 5'b01101;
  localparam logic [4:0] MODE_STA = 5'b10001;
  localparam logic [4:0] MODE_LDA = 5'b10101;
  localparam logic [4:0] MODE_CMP = 5'b11001;
  localparam logic [4:0] MODE_SBC = 5'b11101;

  // Addressing-mode select values (same field, different opcode groups)
  localparam logic [4:0] AM_ZPX = 5'b00001;
  localparam logic [4:0] AM_ZP  = 5'b00101;
  localparam logic [4:0] AM_IMM = 5'b01001;
  localparam logic [4:0] AM_ABS = 5'b01101;
  localparam logic [4:0] AM_ZPY = 5'b10001;

  // Status flags produced by one ALU operation
  typedef struct packed {
    logic c;
    logic z;
    logic n;
    logic v;
  } alu_flags_t;

  // Two's-complement overflow of an addition: both operands share a sign
  // and the result's sign differs from it.
  function automatic logic add_overflow(input logic op_a_msb,
                                        input logic op_b_msb,
                                        input logic res_msb);
    add_overflow = (op_a_msb == op_b_msb) && (res_msb != op_a_msb);
  endfunction

endpackage

// File: rtl/alu_pc_unit_if.sv
// Bus bundle between the ALU/PC unit and its controller. The master drives
// operands, mode and PC controls; the slave (the unit) returns result,
// flags and the current program counter.
interface alu_pc_unit_if;

  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        carry_in;
  logic [4:0]  mode;
  logic [7:0]  alu_out;
  logic        carry_out;
  logic        zero_out;
  logic        neg_out;
  logic        ovf_out;
  logic        pc_load;
  logic        pc_inc;
  logic [15:0] pc_in;
  logic [15:0] pc_out;

  modport master (
    output alu_a, alu_b, carry_in, mode, pc_load, pc_inc, pc_in,
    input  alu_out, carry_out, zero_out, neg_out, ovf_out, pc_out
  );

  modport slave (
    input  alu_a, alu_b, carry_in, mode, pc_load, pc_inc, pc_in,
    output alu_out, carry_out, zero_out, neg_out, ovf_out, pc_out
  );

endinterface

// File: rtl/alu_pc_unit_alu_core.sv
// Combinational 8-bit binary ALU (no decimal mode). Result and C/Z/N/V flags
// follow the inputs with no clock and no reset dependence.
module alu_core
  import cpu_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       carry_in,
  input  logic [4:0] mode,
  output logic [7:0] result,
  output logic       carry_out,
  output logic       zero_out,
  output logic       neg_out,
  output logic       ovf_out
);

  logic [7:0] b_inv_s;
  logic [8:0] add_s;
  logic [8:0] sub_s;
  logic [8:0] cmp_s;
  logic [7:0] result_s;
  alu_flags_t flags_s;

  // Subtraction is addition of the inverted operand; bit 8 is "no borrow".
  assign b_inv_s = ~b;
  assign add_s   = {1'b0, a} + {1'b0, b}       + {8'd0, carry_in};
  assign sub_s   = {1'b0, a} + {1'b0, b_inv_s} + {8'd0, carry_in};
  // Compare always forces the carry-in so it behaves as a true A - B.
  assign cmp_s   = {1'b0, a} + {1'b0, b_inv_s} + 9'd1;

  // Operation decode: result, carry and overflow per mode; Z/N from the result.
  always_comb begin
    result_s  = 8'h00;
    flags_s.c = carry_in;
    flags_s.v = 1'b0;
    case (mode)
      MODE_ORA: result_s = a | b;
      MODE_AND: result_s = a & b;
      MODE_EOR: result_s = a ^ b;
      MODE_STA: result_s = a;
      MODE_LDA: result_s = b;
      MODE_ADC: begin
        result_s  = add_s[7:0];
        flags_s.c = add_s[8];
        flags_s.v = add_overflow(a[7], b[7], add_s[7]);
      end
      MODE_SBC: begin
        result_s  = sub_s[7:0];
        flags_s.c = sub_s[8];
        flags_s.v = add_overflow(a[7], b_inv_s[7], sub_s[7]);
      end
      MODE_CMP: begin
        result_s  = cmp_s[7:0];
        flags_s.c = cmp_s[8];
        flags_s.v = 1'b0;
      end
      default: begin
        result_s  = 8'h00;
        flags_s.c = carry_in;
        flags_s.v = 1'b0;
      end
    endcase
    flags_s.z = (result_s == 8'h00);
    flags_s.n = result_s[7];
  end

  assign result    = result_s;
  assign carry_out = flags_s.c;
  assign zero_out  = flags_s.z;
  assign neg_out   = flags_s.n;
  assign ovf_out   = flags_s.v;

endmodule

// File: rtl/alu_pc_unit.sv
// ALU plus 16-bit program counter. The ALU is purely combinational; the PC
// is a register with async reset and load-over-increment priority.
module alu_pc_unit #(
  parameter logic [15:0] PC_RESET = 16'h0000
) (
  input  logic          clk,
  input  logic          rst,
  alu_pc_unit_if.slave  bus
);

  logic [15:0] pc_d;
  logic [15:0] pc_q;

  alu_core u_alu_core (
    .a         (bus.alu_a),
    .b         (bus.alu_b),
    .carry_in  (bus.carry_in),
    .mode      (bus.mode),
    .result    (bus.alu_out),
    .carry_out (bus.carry_out),
    .zero_out  (bus.zero_out),
    .neg_out   (bus.neg_out),
    .ovf_out   (bus.ovf_out)
  );

  // Next PC: load wins over increment; increment wraps across PCH:PCL.
  always_comb begin
    pc_d = pc_q;
    if (bus.pc_load) begin
      pc_d = bus.pc_in;
    end else if (bus.pc_inc) begin
      pc_d = pc_q + 16'd1;
    end else begin
      pc_d = pc_q;
    end
  end

  // PC register; reset forces PC_RESET immediately, independent of clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= PC_RESET;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign bus.pc_out = pc_q;

endmodule

// File: tb/tb_alu_pc_unit.sv
// Self-checking bench for alu_pc_unit: directed vectors plus randomized
// stimulus compared against an arithmetic reference model.
module tb_alu_pc_unit;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  logic [15:0] pc_m;

  alu_pc_unit_if bus ();

  alu_pc_unit #(.PC_RESET(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Reference model: {out[7:0], c, z, n, v} from plain integer arithmetic.
  function automatic logic [11:0] ref_alu(input logic [4:0] m, input logic [7:0] a,
                                          input logic [7:0] b, input logic ci);
    int ua, ub, sa, sb, c_i, r, sr;
    logic [7:0] o;
    logic c, v;
    ua = a; ub = b; c_i = ci;
    sa = $signed(a); sb = $signed(b);
    o = 8'h00; c = ci; v = 1'b0;
    case (m)
      5'b00001: o = a | b;
      5'b00101: o = a & b;
      5'b01001: o = a ^ b;
      5'b10001: o = a;
      5'b10101: o = b;
      5'b01101: begin
        r = ua + ub + c_i;           o = r[7:0]; c = (r > 255);
        sr = sa + sb + c_i;          v = (sr > 127) || (sr < -128);
      end
      5'b11101: begin
        r = ua - ub - (1 - c_i);     o = r[7:0]; c = (r >= 0);
        sr = sa - sb - (1 - c_i);    v = (sr > 127) || (sr < -128);
      end
      5'b11001: begin
        r = ua - ub;                 o = r[7:0]; c = (ua >= ub);
      end
      default: begin
        o = 8'h00; c = ci;
      end
    endcase
    ref_alu = {o, c, (o == 8'h00), o[7], v};
  endfunction

  task automatic alu_apply(input logic [4:0] m, input logic [7:0] a,
                           input logic [7:0] b, input logic ci);
    bus.mode = m; bus.alu_a = a; bus.alu_b = b; bus.carry_in = ci;
    #1;
  endtask

  task automatic alu_check_model(input string tag);
    logic [11:0] e;
    e = ref_alu(bus.mode, bus.alu_a, bus.alu_b, bus.carry_in);
    check({tag, ".out"}, {24'd0, bus.alu_out}, {24'd0, e[11:4]});
    check({tag, ".c"}, {31'd0, bus.carry_out}, {31'd0, e[3]});
    check({tag, ".z"}, {31'd0, bus.zero_out},  {31'd0, e[2]});
    check({tag, ".n"}, {31'd0, bus.neg_out},   {31'd0, e[1]});
    check({tag, ".v"}, {31'd0, bus.ovf_out},   {31'd0, e[0]});
  endtask

  // One clock: drive PC controls on negedge, sample 1ns after posedge.
  task automatic pc_step(input logic ld, input logic inc, input logic [15:0] din, input string tag);
    @(negedge clk);
    bus.pc_load = ld; bus.pc_inc = inc; bus.pc_in = din;
    @(posedge clk);
    #1;
    if (!rst) begin
      if (ld) pc_m = din;
      else if (inc) pc_m = pc_m + 16'd1;
    end
    check(tag, {16'd0, bus.pc_out}, {16'd0, pc_m});
  endtask

  initial begin
    logic [4:0] valid_modes [8];
    n_checks = 0;
    n_pass   = 0;
    valid_modes = '{5'b00001, 5'b00101, 5'b01001, 5'b01101,
                    5'b10001, 5'b10101, 5'b11001, 5'b11101};
    rst = 1'b1;
    bus.pc_load = 1'b0; bus.pc_inc = 1'b0; bus.pc_in = 16'h0000;
    bus.mode = 5'b00000; bus.alu_a = 8'h00; bus.alu_b = 8'h00; bus.carry_in = 1'b0;
    #1;
    check("pc_async_reset", {16'd0, bus.pc_out}, 32'h0000_0000);
    pc_m = 16'h0000;

    // ALU is live during reset
    alu_apply(5'b01101, 8'h50, 8'h50, 1'b0);
    check("adc_in_reset.out", {24'd0, bus.alu_out}, 32'h0000_00A0);

    pc_step(1'b1, 1'b1, 16'h5555, "pc_held_in_reset");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("pc_after_release", {16'd0, bus.pc_out}, 32'h0000_0000);

    // Directed ALU vectors
    alu_apply(5'b01101, 8'h50, 8'h50, 1'b0);
    check("adc50.out", {24'd0, bus.alu_out}, 32'h0000_00A0);
    check("adc50.c", {31'd0, bus.carry_out}, 32'd0);
    check("adc50.v", {31'd0, bus.ovf_out}, 32'd1);
    check("adc50.n", {31'd0, bus.neg_out}, 32'd1);
    check("adc50.z", {31'd0, bus.zero_out}, 32'd0);
    alu_apply(5'b11101, 8'h50, 8'hF0, 1'b1);
    check("sbc.out", {24'd0, bus.alu_out}, 32'h0000_0060);
    check("sbc.c", {31'd0, bus.carry_out}, 32'd0);
    check("sbc.v", {31'd0, bus.ovf_out}, 32'd0);
    alu_apply(5'b01101, 8'hFF, 8'h01, 1'b0);
    check("adcff.out", {24'd0, bus.alu_out}, 32'h0000_0000);
    check("adcff.c", {31'd0, bus.carry_out}, 32'd1);
    check("adcff.z", {31'd0, bus.zero_out}, 32'd1);
    alu_apply(5'b11001, 8'h10, 8'h10, 1'b0);
    check("cmpeq.out", {24'd0, bus.alu_out}, 32'h0000_0000);
    check("cmpeq.z", {31'd0, bus.zero_out}, 32'd1);
    check("cmpeq.c", {31'd0, bus.carry_out}, 32'd1);
    alu_apply(5'b11001, 8'h0F, 8'h10, 1'b1);
    check("cmplt.out", {24'd0, bus.alu_out}, 32'h0000_00FF);
    check("cmplt.c", {31'd0, bus.carry_out}, 32'd0);
    check("cmplt.n", {31'd0, bus.neg_out}, 32'd1);
    alu_apply(5'b00001, 8'hF0, 8'h0F, 1'b0);
    check("ora.out", {24'd0, bus.alu_out}, 32'h0000_00FF);
    check("ora.n", {31'd0, bus.neg_out}, 32'd1);
    alu_apply(5'b00101, 8'hF0, 8'h0F, 1'b1);
    check("and.out", {24'd0, bus.alu_out}, 32'h0000_0000);
    check("and.z", {31'd0, bus.zero_out}, 32'd1);
    check("and.c", {31'd0, bus.carry_out}, 32'd1);
    alu_apply(5'b01001, 8'hAA, 8'hFF, 1'b1);
    check("eor.out", {24'd0, bus.alu_out}, 32'h0000_0055);
    check("eor.c", {31'd0, bus.carry_out}, 32'd1);
    alu_apply(5'b10001, 8'h81, 8'h22, 1'b0);
    check("sta.out", {24'd0, bus.alu_out}, 32'h0000_0081);
    alu_apply(5'b10101, 8'h81, 8'h22, 1'b1);
    check("lda.out", {24'd0, bus.alu_out}, 32'h0000_0022);
    alu_apply(5'b00010, 8'hFF, 8'hFF, 1'b1);
    check("bad_mode.out", {24'd0, bus.alu_out}, 32'd0);
    check("bad_mode.c", {31'd0, bus.carry_out}, 32'd1);
    check("bad_mode.z", {31'd0, bus.zero_out}, 32'd1);

    // Randomized ALU against the model
    for (int i = 0; i < 400; i++) begin
      logic [4:0] m;
      if (($urandom % 4) != 0) m = valid_modes[$urandom % 8];
      else m = 5'($urandom);
      alu_apply(m, 8'($urandom), 8'($urandom), 1'($urandom));
      alu_check_model("alu_rand");
    end

    // Directed PC sequence
    pc_step(1'b1, 1'b0, 16'hFFFE, "pc_load_fffe");
    check("pc_fffe_const", {16'd0, bus.pc_out}, 32'h0000_FFFE);
    pc_step(1'b0, 1'b1, 16'h0000, "pc_inc_ffff");
    check("pc_ffff_const", {16'd0, bus.pc_out}, 32'h0000_FFFF);
    pc_step(1'b0, 1'b1, 16'h0000, "pc_wrap");
    check("pc_wrap_const", {16'd0, bus.pc_out}, 32'h0000_0000);
    pc_step(1'b1, 1'b1, 16'h1234, "pc_load_inc");
    check("pc_1234_const", {16'd0, bus.pc_out}, 32'h0000_1234);
    pc_step(1'b0, 1'b0, 16'hBEEF, "pc_hold");
    pc_step(1'b1, 1'b0, 16'h00FF, "pc_load_00ff");
    pc_step(1'b0, 1'b1, 16'h0000, "pc_pcl_carry");
    check("pc_0100_const", {16'd0, bus.pc_out}, 32'h0000_0100);

    // Asynchronous reset between edges while counting
    pc_step(1'b0, 1'b1, 16'h0000, "pc_count");
    #2;
    rst = 1'b1;
    #1;
    check("pc_async_mid", {16'd0, bus.pc_out}, 32'h0000_0000);
    pc_m = 16'h0000;
    pc_step(1'b0, 1'b1, 16'h0000, "pc_reset_hold1");
    pc_step(1'b1, 1'b1, 16'h7777, "pc_reset_hold2");
    @(negedge clk);
    bus.pc_load = 1'b0; bus.pc_inc = 1'b1;
    rst = 1'b0;
    #1;
    check("pc_release_hold", {16'd0, bus.pc_out}, 32'h0000_0000);
    @(posedge clk);
    #1;
    pc_m = 16'h0001;
    check("pc_first_inc", {16'd0, bus.pc_out}, 32'h0000_0001);

    // Randomized PC controls against the model
    for (int i = 0; i < 400; i++) begin
      logic [15:0] din;
      din = (($urandom % 2) == 0) ? 16'($urandom) : (16'hFFFF - 16'($urandom % 4));
      pc_step(1'(($urandom % 6) == 0), 1'($urandom), din, "pc_rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_pc_unit.md
ALU_PC_UNIT -- requirements
Module: alu_pc_unit

Interface
REQ-001 Parameter: PC_RESET, default 16'h0000, program-counter value loaded on reset.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 alu_a  input  8  ALU operand A (accumulator side).
REQ-005 alu_b  input  8  ALU operand B (memory/immediate side).
REQ-006 carry_in  input  1  carry flag from the status register.
REQ-007 mode  input  5  operation select, {opcode[7:5], opcode[1:0]}.
REQ-008 alu_out  output  8  ALU result.
REQ-009 carry_out, zero_out, neg_out, ovf_out  output  1 each  C, Z, N, V flags of the current operation.
REQ-010 pc_load  input  1  load pc_in into the program counter.
REQ-011 pc_inc  input  1  increment the program counter.
REQ-012 pc_in  input  16  program-counter load value.
REQ-013 pc_out  output  16  current program counter; pc_out[15:8] = PCH, pc_out[7:0] = PCL.

Function
REQ-014 ALU is purely combinational; outputs settle within the same cycle as inputs, with zero clock latency.
REQ-015 ORA (5'b00001): alu_out = A | B.
REQ-016 AND (5'b00101): alu_out = A & B.
REQ-017 EOR (5'b01001): alu_out = A ^ B.
REQ-018 ADC (5'b01101): 9-bit sum A + B + carry_in; alu_out = sum[7:0]; carry_out = sum[8].
REQ-019 SBC (5'b11101): A + ~B + carry_in; carry_out = 1 when there is no borrow.
REQ-020 CMP (5'b11001): computes A + ~B + 1 and ignores carry_in; carry_out = (A >= B unsigned); alu_out = A - B.
REQ-021 STA (5'b10001): alu_out = A. LDA (5'b10101): alu_out = B.
REQ-022 ovf_out = 1 for ADC/SBC only, when the operand signs (A, and B or ~B) agree and the result sign differs; otherwise ovf_out = 0.
REQ-023 For ORA/AND/EOR/STA/LDA, carry_out = carry_in.
REQ-024 zero_out = (alu_out == 0); neg_out = alu_out[7], for every mode.
REQ-025 Any unlisted mode: alu_out = 0, carry_out = carry_in, ovf_out = 0; zero_out and neg_out follow REQ-024.
REQ-026 Decimal (BCD) mode is not supported; all arithmetic is binary.
REQ-027 Program counter is a 16-bit register; priority per clk edge is rst > pc_load > pc_inc > hold.
REQ-028 pc_inc increments by 1 modulo 2^16, so 16'hFFFF wraps to 16'h0000 and the carry from PCL propagates into PCH.
REQ-029 When pc_load and pc_inc are both asserted, pc_out takes pc_in (no increment).

Reset
REQ-030 While rst is high, pc_out = PC_RESET immediately, independent of clk.
REQ-031 On rst deassertion, pc_out holds PC_RESET until the next enabled clk edge.
REQ-032 ALU outputs have no reset state; they always reflect the current inputs, including during reset.

Structure
REQ-033 Shared package cpu_pkg holds the 5-bit ALU mode constants (ORA, AND, EOR, ADC, STA, LDA, CMP, SBC) and the addressing-mode constants (ZPX 00001, ZP 00101, IMM 01001, ABS 01101, ZPY 10001).
REQ-034 One sub-module, alu_core, implements the combinational ALU (REQ-014..026); the PC register resides in alu_pc_unit.

Verification
REQ-035 ADC A=0x50, B=0x50, cin=0 -> alu_out 0xA0, C=0, V=1, N=1, Z=0.
REQ-036 SBC A=0x50, B=0xF0, cin=1 -> alu_out 0x60, C=0, V=0. ADC A=0xFF, B=0x01, cin=0 -> alu_out 0x00, C=1, Z=1.
REQ-037 Compare and logic operations:
- CMP A=0x10, B=0x10, cin=0 -> alu_out 0x00, Z=1, C=1.
- CMP A=0x0F, B=0x10 -> alu_out 0xFF, C=0, N=1.
- ORA 0xF0|0x0F -> 0xFF, N=1.
- AND 0xF0&0x0F -> 0x00, Z=1.
- EOR 0xAA^0xFF -> 0x55, with C = cin.
REQ-038 PC sequence:
- Reset -> 0x0000.
- Load 0xFFFE, then inc for 2 cycles -> 0xFFFF, then 0x0000.
- pc_load=pc_inc=1 with pc_in=0x1234 -> 0x1234.
REQ-039 Assert rst between clk edges while PC counts -> pc_out becomes 0x0000 before the next edge and stays there until rst falls.
